pov_digit_sequencer: RTL and testbench



---
 rtl/pov_digit_sequencer.sv | 128 ++++++++++++
 tb/tb_pov_digit_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pov_digit_sequencer.sv
// Time-slot sequencer: drives a shared segment bus with one digit pattern per slot,
// blanking between digits and an extra gap after every group, restarting once per frame.
module pov_digit_sequencer #(
    parameter int N_DIGITS  = 6,
    parameter int SEG_W     = 7,
    parameter int ON_CYC    = 1,
    parameter int BLANK_CYC = 3,
    parameter int GROUP     = 2,
    parameter int GAP_CYC   = 20,
    parameter int FRAME_CYC = 900,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      dir,
    input  logic [N_DIGITS*SEG_W-1:0] digits_in,
    output logic [SEG_W-1:0]          seg_out,
    output logic                      seg_valid,
    output logic [IDX_W-1:0]          digit_idx,
    output logic                      frame_start
);

    localparam int NEED_CYC = 1 + N_DIGITS * (ON_CYC + BLANK_CYC)
                            + ((N_DIGITS + GROUP - 1) / GROUP - 1) * GAP_CYC;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_CYC - 1);

    generate
        if (NEED_CYC > FRAME_CYC) begin : g_frame_too_short
            $error("pov_digit_sequencer: slot schedule needs %0d cycles, FRAME_CYC is %0d",
                   NEED_CYC, FRAME_CYC);
        end
        if (longint'(FRAME_CYC - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_too_narrow
            $error("pov_digit_sequencer: CNT_W too small for FRAME_CYC");
        end
    endgenerate

    function automatic int slot_start(input int j);
        return 1 + j * (ON_CYC + BLANK_CYC) + (j / GROUP) * GAP_CYC;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
    logic                      dir_q, dir_d;
    logic [SEG_W-1:0]          seg_d;
    logic                      valid_d;
    logic [IDX_W-1:0]          idx_d;
    logic                      fs_d;
    logic                      restart;
    logic                      hit;
    logic [CNT_W-1:0]          s_lo;
    logic [SEG_W-1:0]          pat;
    logic [IDX_W-1:0]          phys;
    int                        pj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            dir_q       <= 1'b0;
            seg_out     <= '0;
            seg_valid   <= 1'b0;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            dir_q       <= dir_d;
            seg_out     <= seg_d;
            seg_valid   <= valid_d;
            digit_idx   <= idx_d;
            frame_start <= fs_d;
        end
    end

    // Outputs are computed for the cycle the counter is about to enter, so they stay registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        restart  = 1'b0;
        hit      = 1'b0;
        s_lo     = '0;
        pat      = '0;
        phys     = '0;
        pj       = 0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE || sync || cnt_q == LAST_C) begin
            restart  = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
            shadow_d = digits_in;
            dir_d    = dir;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Cycle 0 never falls in a slot, so the old dir/shadow are safe to use here.
        for (int j = 0; j < N_DIGITS; j++) begin
            s_lo = CNT_W'(slot_start(j));
            if (state_d == RUN && cnt_d >= s_lo && cnt_d < s_lo + CNT_W'(ON_CYC)) begin
                hit  = 1'b1;
                pj   = dir_q ? (N_DIGITS - 1 - j) : j;
                pat  = shadow_q[pj*SEG_W +: SEG_W];
                phys = IDX_W'(pj);
            end
        end

        seg_d   = hit ? pat : '0;
        valid_d = hit;
        fs_d    = restart;
        if (hit)                 idx_d = phys;
        else if (state_d == IDLE) idx_d = '0;
        else                     idx_d = digit_idx;
    end

endmodule

// File: tb/tb_pov_digit_sequencer.sv
// Directed bench for pov_digit_sequencer at default parameters: schedule, direction,
// snapshot, sync restart, enable drop and asynchronous reset.
module tb_pov_digit_sequencer;

    localparam int N = 6;
    localparam int W = 7;
    localparam int FRAME = 900;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic           dir = 1'b0;
    logic [N*W-1:0] digits_in = '0;
    logic [W-1:0]   seg_out;
    logic           seg_valid;
    logic [2:0]     digit_idx;
    logic           frame_start;

    int vectors = 0;
    int errors  = 0;

    // Hand-computed slot start cycles: 1 + 4j + (j/2)*20
    int          slot_c [N] = '{1, 5, 29, 33, 57, 61};
    logic [W-1:0] pat_old [N] = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06};
    logic [W-1:0] pat_new [N] = '{7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h16};

    pov_digit_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .dir(dir),
        .digits_in(digits_in), .seg_out(seg_out), .seg_valid(seg_valid),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int slot_at(input int c);
        for (int j = 0; j < N; j++)
            if (slot_c[j] == c) return j;
        return -1;
    endfunction

    task automatic load_old();
        for (int k = 0; k < N; k++) digits_in[k*W +: W] = pat_old[k];
    endtask

    task automatic load_new();
        for (int k = 0; k < N; k++) digits_in[k*W +: W] = pat_new[k];
    endtask

    // Pulse sync for one edge; the following cycle is frame cycle 0.
    task automatic restart_frame();
        sync = 1'b1;
        step();
        sync = 1'b0;
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_fs: frame_start=%b expected 1", frame_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        step();
        vectors += 4;
        if (seg_out !== '0)      begin errors++; $display("FAIL reset_seg: got %h expected 00", seg_out); end
        if (seg_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", seg_valid); end
        if (digit_idx !== 3'd0)  begin errors++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    endtask

    task automatic test_frame_dir0();
        int j;
        logic [W-1:0] e_seg;
        logic         e_v;
        logic [2:0]   e_idx;
        load_old();
        dir = 1'b0;
        rst_n = 1'b1;
        en = 1'b1;
        step();
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b expected 1", frame_start); end
        e_idx = 3'd0;
        for (int c = 1; c < FRAME; c++) begin
            step();
            j = slot_at(c);
            e_v = (j >= 0);
            e_seg = e_v ? pat_old[j] : '0;
            if (e_v) e_idx = 3'(j);
            vectors += 4;
            if (seg_valid !== e_v)    begin errors++; $display("FAIL dir0_valid c=%0d: got %b expected %b", c, seg_valid, e_v); end
            if (seg_out !== e_seg)    begin errors++; $display("FAIL dir0_seg c=%0d: got %h expected %h", c, seg_out, e_seg); end
            if (digit_idx !== e_idx)  begin errors++; $display("FAIL dir0_idx c=%0d: got %0d expected %0d", c, digit_idx, e_idx); end
            if (frame_start !== 1'b0) begin errors++; $display("FAIL dir0_fs c=%0d: got %b expected 0", c, frame_start); end
        end
        step();
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL period_fs: got %b expected 1 after 900 cycles", frame_start); end
    endtask

    task automatic test_dir1();
        dir = 1'b1;
        restart_frame();
        for (int c = 1; c <= 61; c++) begin
            step();
            if (slot_at(c) >= 0) begin
                vectors += 2;
                if (seg_out !== pat_old[N-1-slot_at(c)]) begin
                    errors++; $display("FAIL dir1_seg c=%0d: got %h expected %h", c, seg_out, pat_old[N-1-slot_at(c)]);
                end
                if (digit_idx !== 3'(N-1-slot_at(c))) begin
                    errors++; $display("FAIL dir1_idx c=%0d: got %0d expected %0d", c, digit_idx, N-1-slot_at(c));
                end
            end
        end
        dir = 1'b0;
    endtask

    task automatic test_snapshot();
        load_old();
        restart_frame();
        for (int c = 1; c < FRAME; c++) begin
            step();
            if (c == 10) load_new();
            if (slot_at(c) >= 2) begin
                vectors++;
                if (seg_out !== pat_old[slot_at(c)]) begin
                    errors++; $display("FAIL snap_old c=%0d: got %h expected %h", c, seg_out, pat_old[slot_at(c)]);
                end
            end
        end
        step();
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL snap_fs: got %b expected 1", frame_start); end
        for (int c = 1; c <= 61; c++) begin
            step();
            if (slot_at(c) >= 0) begin
                vectors++;
                if (seg_out !== pat_new[slot_at(c)]) begin
                    errors++; $display("FAIL snap_new c=%0d: got %h expected %h", c, seg_out, pat_new[slot_at(c)]);
                end
            end
        end
        load_old();
    endtask

    task automatic test_sync();
        logic e_v;
        restart_frame();
        for (int c = 1; c <= 30; c++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        vectors += 2;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL sync_fs: got %b expected 1", frame_start); end
        if (seg_valid !== 1'b0)   begin errors++; $display("FAIL sync_blank: got %b expected 0", seg_valid); end
        for (int c = 1; c <= 6; c++) begin
            step();
            e_v = (c == 1 || c == 5);
            vectors++;
            if (seg_valid !== e_v) begin errors++; $display("FAIL sync_valid c=%0d: got %b expected %b", c, seg_valid, e_v); end
            if (c == 1) begin
                vectors++;
                if (seg_out !== 7'h01) begin errors++; $display("FAIL sync_seg1: got %h expected 01", seg_out); end
            end
        end
    endtask

    task automatic test_en_drop();
        restart_frame();
        for (int c = 1; c <= 5; c++) step();
        vectors++;
        if (seg_out !== 7'h02) begin errors++; $display("FAIL en_pre: got %h expected 02", seg_out); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors += 4;
            if (seg_out !== '0)       begin errors++; $display("FAIL idle_seg: got %h expected 00", seg_out); end
            if (seg_valid !== 1'b0)   begin errors++; $display("FAIL idle_valid: got %b expected 0", seg_valid); end
            if (digit_idx !== 3'd0)   begin errors++; $display("FAIL idle_idx: got %0d expected 0", digit_idx); end
            if (frame_start !== 1'b0) begin errors++; $display("FAIL idle_fs: got %b expected 0", frame_start); end
        end
        en = 1'b1;
        step();
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL reen_fs: got %b expected 1", frame_start); end
        step();
        vectors += 2;
        if (seg_valid !== 1'b1) begin errors++; $display("FAIL reen_valid: got %b expected 1", seg_valid); end
        if (seg_out !== 7'h01)  begin errors++; $display("FAIL reen_seg: got %h expected 01", seg_out); end
    endtask

    task automatic test_reset_mid();
        restart_frame();
        for (int c = 1; c <= 29; c++) step();
        vectors++;
        if (seg_out !== 7'h03) begin errors++; $display("FAIL rstmid_pre: got %h expected 03", seg_out); end
        #1 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (seg_out !== '0)     begin errors++; $display("FAIL rstmid_seg: got %h expected 00", seg_out); end
        if (seg_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", seg_valid); end
        if (digit_idx !== 3'd0) begin errors++; $display("FAIL rstmid_idx: got %0d expected 0", digit_idx); end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL rstmid_fs: got %b expected 1", frame_start); end
        step();
        vectors++;
        if (seg_out !== 7'h01) begin errors++; $display("FAIL rstmid_seg1: got %h expected 01", seg_out); end
    endtask

    initial begin
        test_reset();
        test_frame_dir0();
        test_dir1();
        test_snapshot();
        test_sync();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
